// File: rtl/branch_resolve_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_pkg
// Shared constants and types for branch resolution in the execute stage.
//   OP_B / OP_BR      : branch opcodes (PC-relative / register target)
//   CC_*              : branch condition field encodings
//   state_t           : redirect/flush sequencer states
//   N_IDX/V_IDX/Z_IDX : bit positions inside the {N,V,Z} flag vector
// ---------------------------------------------------------------------------
package branch_resolve_pkg;

   localparam logic [3:0] OP_B  = 4'b1100;
   localparam logic [3:0] OP_BR = 4'b1101;

   localparam logic [2:0] CC_NE     = 3'b000;
   localparam logic [2:0] CC_EQ     = 3'b001;
   localparam logic [2:0] CC_GT     = 3'b010;
   localparam logic [2:0] CC_LT     = 3'b011;
   localparam logic [2:0] CC_GTE    = 3'b100;
   localparam logic [2:0] CC_LTE    = 3'b101;
   localparam logic [2:0] CC_OVFL   = 3'b110;
   localparam logic [2:0] CC_UNCOND = 3'b111;

   localparam int N_IDX = 2;
   localparam int V_IDX = 1;
   localparam int Z_IDX = 0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

endpackage

// File: rtl/branch_cond.sv
// ---------------------------------------------------------------------------
// branch_cond
// Purely combinational branch condition evaluator; also used by the hazard
// unit, so it carries no state and no pipeline knowledge.
//   ccc  : condition field
//   nvz  : flags {N,V,Z}
//   cond : 1 when the selected condition holds
// ---------------------------------------------------------------------------
module branch_cond
   import branch_resolve_pkg::*;
(
   input  logic [2:0] ccc,
   input  logic [2:0] nvz,
   output logic       cond
);

   logic n, v, z;

   assign n = nvz[N_IDX];
   assign v = nvz[V_IDX];
   assign z = nvz[Z_IDX];

   always_comb begin
      cond = 1'b0;
      case (ccc)
         CC_NE:     cond = ~z;
         CC_EQ:     cond = z;
         CC_GT:     cond = ~z & ~n;
         CC_LT:     cond = n;
         CC_GTE:    cond = z | (~z & ~n);
         CC_LTE:    cond = n | z;
         CC_OVFL:   cond = v;
         CC_UNCOND: cond = 1'b1;
         default:   cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Resolves B/BR in the execute stage, drives a registered PC redirect and
// then holds flush for FLUSH_CYCLES cycles in total (redirect cycle included).
// Optional saturating statistics counters: define BRANCH_STATS_EN.
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : freezes sequencer, counters and registered outputs
//   inst_valid, opcode, ccc, imm9, pc_plus2, rs_data, NVZ : execute slot
//   taken           : combinational, live branch with true condition (IDLE)
//   redirect_valid, redirect_pc : registered PC load request and target
//   flush           : registered squash of fetch/decode
//   busy            : sequencer not IDLE
//   br_count, tk_count : resolved / taken branch counters (0 when disabled)
// ---------------------------------------------------------------------------
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int PC_W         = 16
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            inst_valid,
   input  logic [3:0]      opcode,
   input  logic [2:0]      ccc,
   input  logic [8:0]      imm9,
   input  logic [PC_W-1:0] pc_plus2,
   input  logic [PC_W-1:0] rs_data,
   input  logic [2:0]      NVZ,
   output logic            taken,
   output logic            redirect_valid,
   output logic [PC_W-1:0] redirect_pc,
   output logic            flush,
   output logic            busy,
   output logic [15:0]     br_count,
   output logic [15:0]     tk_count
);

   localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

   state_t          state_reg, state_next;
   logic [2:0]      cnt_reg, cnt_next;
   logic            redirect_valid_reg, redirect_valid_next;
   logic            flush_reg, flush_next;
   logic [PC_W-1:0] redirect_pc_reg, redirect_pc_next;

   logic            is_br, cond;
   logic [PC_W-1:0] imm_sx, b_offset, target;

   branch_cond u_cond (
      .ccc  (ccc),
      .nvz  (NVZ),
      .cond (cond)
   );

   assign is_br = inst_valid && ((opcode == OP_B) || (opcode == OP_BR));
   // Wrong-path instructions arrive while redirecting/flushing: never taken.
   assign taken = is_br && cond && (state_reg == IDLE);

   // Word offset: sign-extend then scale to bytes; the sum wraps silently.
   assign imm_sx   = {{(PC_W-9){imm9[8]}}, imm9};
   assign b_offset = {imm_sx[PC_W-2:0], 1'b0};
   assign target   = (opcode == OP_BR) ? rs_data : (pc_plus2 + b_offset);

   always_comb begin
      state_next          = state_reg;
      cnt_next            = cnt_reg;
      redirect_valid_next = redirect_valid_reg;
      flush_next          = flush_reg;
      redirect_pc_next    = redirect_pc_reg;
      if (!stall) begin
         case (state_reg)
            IDLE: begin
               if (taken) begin
                  state_next          = REDIRECT;
                  redirect_valid_next = 1'b1;
                  flush_next          = 1'b1;
                  redirect_pc_next    = target;
               end
            end
            REDIRECT: begin
               redirect_valid_next = 1'b0;
               if (FLUSH_CYCLES <= 1) begin
                  state_next = IDLE;
                  flush_next = 1'b0;
                  cnt_next   = 3'd0;
               end else begin
                  state_next = FLUSH;
                  cnt_next   = CNT_INIT;
               end
            end
            FLUSH: begin
               // Counter holds the flush cycles still owed, including this
               // one; the sequencer leaves as the count reaches zero.
               if (cnt_reg <= 3'd1) begin
                  state_next = IDLE;
                  flush_next = 1'b0;
                  cnt_next   = 3'd0;
               end else begin
                  cnt_next = cnt_reg - 3'd1;
               end
            end
            default: begin
               state_next          = IDLE;
               redirect_valid_next = 1'b0;
               flush_next          = 1'b0;
               cnt_next            = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg          <= IDLE;
         cnt_reg            <= 3'd0;
         redirect_valid_reg <= 1'b0;
         flush_reg          <= 1'b0;
         redirect_pc_reg    <= '0;
      end else begin
         state_reg          <= state_next;
         cnt_reg            <= cnt_next;
         redirect_valid_reg <= redirect_valid_next;
         flush_reg          <= flush_next;
         redirect_pc_reg    <= redirect_pc_next;
      end
   end

   assign redirect_valid = redirect_valid_reg;
   assign redirect_pc    = redirect_pc_reg;
   assign flush          = flush_reg;
   assign busy           = (state_reg != IDLE);

`ifdef BRANCH_STATS_EN
   logic [15:0] br_count_reg, tk_count_reg;
   logic        count_en;

   assign count_en = is_br && !stall && (state_reg == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_count_reg <= 16'd0;
         tk_count_reg <= 16'd0;
      end else if (count_en) begin
         if (br_count_reg != 16'hFFFF)
            br_count_reg <= br_count_reg + 16'd1;
         if (taken && (tk_count_reg != 16'hFFFF))
            tk_count_reg <= tk_count_reg + 16'd1;
      end
   end

   assign br_count = br_count_reg;
   assign tk_count = tk_count_reg;
`else
   assign br_count = 16'd0;
   assign tk_count = 16'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
// Directed bench: stimulus pushes expected redirect targets into a queue and a
// monitor pops one per redirect presented by the DUT. Cycle-level expectations
// (taken, flush, busy, counters) are checked inline against hand values.
// ---------------------------------------------------------------------------
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        inst_valid = 1'b0;
   logic [3:0]  opcode = 4'd0;
   logic [2:0]  ccc = 3'd0;
   logic [8:0]  imm9 = 9'd0;
   logic [15:0] pc_plus2 = 16'd0;
   logic [15:0] rs_data = 16'd0;
   logic [2:0]  NVZ = 3'd0;
   logic        taken, redirect_valid, flush, busy;
   logic [15:0] redirect_pc, br_count, tk_count;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_pc;
   logic        prev_rv = 1'b0;

`ifdef BRANCH_STATS_EN
   localparam logic [15:0] EXP_BR5 = 16'd5;
   localparam logic [15:0] EXP_TK3 = 16'd3;
   localparam logic [15:0] EXP_BR1 = 16'd1;
`else
   localparam logic [15:0] EXP_BR5 = 16'd0;
   localparam logic [15:0] EXP_TK3 = 16'd0;
   localparam logic [15:0] EXP_BR1 = 16'd0;
`endif

   branch_resolve #(.FLUSH_CYCLES(2), .PC_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .inst_valid     (inst_valid),
      .opcode         (opcode),
      .ccc            (ccc),
      .imm9           (imm9),
      .pc_plus2       (pc_plus2),
      .rs_data        (rs_data),
      .NVZ            (NVZ),
      .taken          (taken),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .busy           (busy),
      .br_count       (br_count),
      .tk_count       (tk_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Hand-written condition table in terms of the {N,V,Z} flags.
   function automatic logic exp_cond(input logic [2:0] c, input logic [2:0] f);
      logic n, v, z;
      n = f[2]; v = f[1]; z = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return z || (!z && !n);
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   // Monitor: one scoreboard pop per redirect (rising edge of redirect_valid).
   always @(negedge clk) begin
      if (redirect_valid && !prev_rv) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_redirect: got pc 0x%0h, expected none", redirect_pc);
         end else begin
            mon_pc = exp_q.pop_front();
            $display("redirect pc=0x%04h expected=0x%04h", redirect_pc, mon_pc);
            chk("redirect_pc", {16'd0, redirect_pc}, {16'd0, mon_pc});
         end
      end
      prev_rv = redirect_valid;
   end

   task automatic drive_b(input logic [2:0] c, input logic [2:0] f,
                          input logic [15:0] p2, input logic [8:0] im);
      inst_valid = 1'b1;
      opcode     = 4'b1100;
      ccc        = c;
      NVZ        = f;
      pc_plus2   = p2;
      imm9       = im;
   endtask

   task automatic drive_none();
      inst_valid = 1'b0;
      opcode     = 4'd0;
   endtask

   // One B in IDLE: checks taken, then the first cycle after, then returns
   // with the DUT back in IDLE at the next negedge.
   task automatic run_b(input string name, input logic [2:0] c, input logic [2:0] f,
                        input logic [15:0] p2, input logic [8:0] im,
                        input logic e_tk, input logic [15:0] e_pc);
      @(negedge clk);
      drive_b(c, f, p2, im);
      if (e_tk) exp_q.push_back(e_pc);
      #1 chk({name, "_taken"}, {31'd0, taken}, {31'd0, e_tk});
      @(negedge clk);
      drive_none();
      chk({name, "_flush"}, {31'd0, flush}, {31'd0, e_tk});
      if (e_tk) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
      chk("rst_pc", {16'd0, redirect_pc}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_br", {16'd0, br_count}, 32'd0);
      chk("rst_tk", {16'd0, tk_count}, 32'd0);
      rst = 1'b0;

      // B EQ taken, 0x0040 + (-2<<1) = 0x003C, flush for 2 cycles
      @(negedge clk);
      drive_b(3'b001, 3'b001, 16'h0040, 9'h1FE);
      exp_q.push_back(16'h003C);
      #1 chk("t1_taken", {31'd0, taken}, 32'd1);
      @(negedge clk);
      drive_none();
      chk("t1_rv", {31'd0, redirect_valid}, 32'd1);
      chk("t1_flush_a", {31'd0, flush}, 32'd1);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("t1_rv_off", {31'd0, redirect_valid}, 32'd0);
      chk("t1_flush_b", {31'd0, flush}, 32'd1);
      @(negedge clk);
      chk("t1_flush_c", {31'd0, flush}, 32'd0);
      chk("t1_idle", {31'd0, busy}, 32'd0);

      // BR unconditional, then a wrong-path B during FLUSH
      @(negedge clk);
      inst_valid = 1'b1; opcode = 4'b1101; ccc = 3'b111; rs_data = 16'hBEEF;
      exp_q.push_back(16'hBEEF);
      #1 chk("t2_taken", {31'd0, taken}, 32'd1);
      @(negedge clk);
      drive_none();
      @(negedge clk);
      drive_b(3'b111, 3'b000, 16'h1000, 9'h010);
      #1 chk("t2_wrongpath_taken", {31'd0, taken}, 32'd0);
      @(negedge clk);
      drive_none();
      chk("t2_flush_end", {31'd0, flush}, 32'd0);
      chk("t2_idle", {31'd0, busy}, 32'd0);

      // Full condition table
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 8; f++) begin
            run_b($sformatf("cc%0d_nvz%0d", c, f), 3'(c), 3'(f), 16'h0100, 9'h000,
                  exp_cond(3'(c), 3'(f)), 16'h0100);
         end
      end

      // Wrap-around target and stall held in REDIRECT
      @(negedge clk);
      drive_b(3'b111, 3'b000, 16'hFFFE, 9'h002);
      exp_q.push_back(16'h0002);
      #1 chk("t4_taken", {31'd0, taken}, 32'd1);
      @(negedge clk);
      drive_none();
      stall = 1'b1;
      chk("t4_rv", {31'd0, redirect_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t4_stall%0d_rv", i), {31'd0, redirect_valid}, 32'd1);
         chk($sformatf("t4_stall%0d_busy", i), {31'd0, busy}, 32'd1);
      end
      stall = 1'b0;
      @(negedge clk);
      chk("t4_flush_rv", {31'd0, redirect_valid}, 32'd0);
      chk("t4_flush", {31'd0, flush}, 32'd1);
      @(negedge clk);
      chk("t4_flush_end", {31'd0, flush}, 32'd0);
      chk("t4_idle", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-FLUSH, then an immediate taken branch
      @(negedge clk);
      drive_b(3'b111, 3'b000, 16'h0200, 9'h010);
      exp_q.push_back(16'h0220);
      #1 chk("t5_taken", {31'd0, taken}, 32'd1);
      @(negedge clk);
      drive_none();
      @(negedge clk);
      chk("t5_in_flush", {31'd0, flush}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t5_arst_flush", {31'd0, flush}, 32'd0);
      chk("t5_arst_rv", {31'd0, redirect_valid}, 32'd0);
      chk("t5_arst_busy", {31'd0, busy}, 32'd0);
      chk("t5_arst_br", {16'd0, br_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive_b(3'b111, 3'b000, 16'h0300, 9'h1FF);
      exp_q.push_back(16'h02FE);
      #1 chk("t5_post_taken", {31'd0, taken}, 32'd1);
      @(negedge clk);
      drive_none();
      chk("t5_post_rv", {31'd0, redirect_valid}, 32'd1);
      @(negedge clk);
      chk("t5_post_br", {16'd0, br_count}, {16'd0, EXP_BR1});

      // Statistics: 5 branches, 3 taken, plus ignored non-branch slots
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_b("st_ne",  3'b000, 3'b000, 16'h0400, 9'h000, 1'b1, 16'h0400);
      run_b("st_eq",  3'b001, 3'b000, 16'h0400, 9'h000, 1'b0, 16'h0400);
      run_b("st_lt",  3'b011, 3'b000, 16'h0400, 9'h000, 1'b0, 16'h0400);
      run_b("st_gt",  3'b010, 3'b000, 16'h0400, 9'h004, 1'b1, 16'h0408);
      run_b("st_unc", 3'b111, 3'b000, 16'h0400, 9'h1F0, 1'b1, 16'h03E0);
      @(negedge clk);
      inst_valid = 1'b1; opcode = 4'b0011; ccc = 3'b111;
      #1 chk("st_nonbr_taken", {31'd0, taken}, 32'd0);
      inst_valid = 1'b0; opcode = 4'b1100;
      #1 chk("st_invalid_taken", {31'd0, taken}, 32'd0);
      @(negedge clk);
      drive_none();
      chk("st_idle", {31'd0, busy}, 32'd0);
      chk("st_br_count", {16'd0, br_count}, {16'd0, EXP_BR5});
      chk("st_tk_count", {16'd0, tk_count}, {16'd0, EXP_TK3});

      repeat (2) @(negedge clk);
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
